// File: rtl/vga_scene_pkg.sv
// Shared types and constants for the VGA scene sequencer.
package vga_scene_pkg;
    localparam int MODE_W = 3;
    localparam int SEL_W  = 3;
    localparam int X_W    = 10;

    localparam logic [3:0] BRIGHT_MAX = 4'd15;
    localparam logic [3:0] BRIGHT_MIN = 4'd0;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        BLANK    = 2'd2,
        FADE_IN  = 2'd3
    } scene_state_t;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [SEL_W-1:0]  sel;
    } scene_t;
endpackage

// File: rtl/scene_scroll_acc.sv
// Modulo scroll accumulator for the title banner: x <- (x + STEP) mod WRAP per tick.
module scene_scroll_acc
    import vga_scene_pkg::*;
#(
    parameter int SCROLL_STEP = 2,
    parameter int SCROLL_WRAP = 640
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           clear,
    output logic [X_W-1:0] x
);
    localparam logic [X_W:0] STEP_L = (X_W+1)'(SCROLL_STEP);
    localparam logic [X_W:0] WRAP_L = (X_W+1)'(SCROLL_WRAP);

    logic [X_W:0]   sum;
    logic [X_W-1:0] x_nxt;

    // One extra bit keeps the pre-wrap sum exact
    always_comb begin
        sum   = {1'b0, x} + STEP_L;
        x_nxt = (sum >= WRAP_L) ? X_W'(sum - WRAP_L) : X_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     x <= '0;
        else if (clear) x <= '0;
        else if (tick)  x <= x_nxt;
    end
endmodule

// File: rtl/vga_scene_ctrl.sv
// Frame-synchronous scene sequencer: swaps scenes via fade-out, blank, fade-in.
module vga_scene_ctrl
    import vga_scene_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int BLANK_FRAMES    = 4,
    parameter int SCROLL_STEP     = 2,
    parameter int SCROLL_WRAP     = 640
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic [MODE_W-1:0] mode,
    input  logic [SEL_W-1:0]  select,
    output logic [MODE_W-1:0] scene_mode,
    output logic [SEL_W-1:0]  scene_select,
    output logic [3:0]        brightness,
    output logic [X_W-1:0]    scroll_x,
    output logic              busy
);
    localparam int CNT_MAX = (FRAMES_PER_STEP > BLANK_FRAMES) ? FRAMES_PER_STEP : BLANK_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_FRAMES - 1);

    scene_state_t     state, state_nxt;
    logic [CNT_W-1:0] fcnt, fcnt_nxt;
    logic [3:0]       bright_nxt;
    scene_t           req, scene;
    logic             latch, scroll_clr, scroll_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SHOW;
            fcnt       <= '0;
            brightness <= BRIGHT_MAX;
            req        <= '0;
            scene      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            fcnt       <= fcnt_nxt;
            brightness <= bright_nxt;
            req        <= '{mode: mode, sel: select};
            if (latch) scene <= req;
            busy       <= (state_nxt != SHOW);
        end
    end

    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        bright_nxt = brightness;
        latch      = 1'b0;
        scroll_clr = 1'b0;
        scroll_adv = 1'b0;
        if (frame_tick) begin
            case (state)
                SHOW: begin
                    scroll_adv = 1'b1;
                    bright_nxt = BRIGHT_MAX;
                    if (req != scene) begin
                        state_nxt = FADE_OUT;
                        fcnt_nxt  = '0;
                    end
                end
                FADE_OUT: begin
                    scroll_adv = 1'b1;
                    if (fcnt == STEP_LAST) begin
                        fcnt_nxt   = '0;
                        bright_nxt = brightness - 4'd1;
                        // Last step: the new scene is taken while the screen is dark
                        if (brightness == BRIGHT_MIN + 4'd1) begin
                            state_nxt  = BLANK;
                            latch      = 1'b1;
                            scroll_clr = 1'b1;
                            scroll_adv = 1'b0;
                        end
                    end else begin
                        fcnt_nxt = fcnt + 1'b1;
                    end
                end
                BLANK: begin
                    bright_nxt = BRIGHT_MIN;
                    if (fcnt == BLANK_LAST) begin
                        state_nxt = FADE_IN;
                        fcnt_nxt  = '0;
                    end else begin
                        fcnt_nxt = fcnt + 1'b1;
                    end
                end
                FADE_IN: begin
                    scroll_adv = 1'b1;
                    if (fcnt == STEP_LAST) begin
                        fcnt_nxt   = '0;
                        bright_nxt = brightness + 4'd1;
                        if (brightness == BRIGHT_MAX - 4'd1) state_nxt = SHOW;
                    end else begin
                        fcnt_nxt = fcnt + 1'b1;
                    end
                end
                default: state_nxt = SHOW;
            endcase
        end
    end

    assign scene_mode   = scene.mode;
    assign scene_select = scene.sel;

    scene_scroll_acc #(
        .SCROLL_STEP(SCROLL_STEP),
        .SCROLL_WRAP(SCROLL_WRAP)
    ) u_scroll (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (scroll_adv),
        .clear(scroll_clr),
        .x    (scroll_x)
    );
endmodule

// File: tb/tb_vga_scene_ctrl.sv
// Directed bench for vga_scene_ctrl with fast fades (1 frame/step, 2 blank frames).
module tb_vga_scene_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] mode = '0;
    logic [2:0] select = '0;
    logic [2:0] scene_mode, scene_select;
    logic [3:0] brightness;
    logic [9:0] scroll_x;
    logic       busy;

    logic       frame_tick2 = 1'b0;
    logic [2:0] mode2 = '0;
    logic [2:0] select2 = '0;
    logic [2:0] scene_mode2, scene_select2;
    logic [3:0] brightness2;
    logic [9:0] scroll_x2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    vga_scene_ctrl #(.FRAMES_PER_STEP(1), .BLANK_FRAMES(2), .SCROLL_STEP(2), .SCROLL_WRAP(640)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mode(mode), .select(select),
        .scene_mode(scene_mode), .scene_select(scene_select), .brightness(brightness),
        .scroll_x(scroll_x), .busy(busy)
    );

    vga_scene_ctrl #(.FRAMES_PER_STEP(1), .BLANK_FRAMES(2), .SCROLL_STEP(7), .SCROLL_WRAP(640)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick2), .mode(mode2), .select(select2),
        .scene_mode(scene_mode2), .scene_select(scene_select2), .brightness(brightness2),
        .scroll_x(scroll_x2), .busy(busy2)
    );

    // Called at a negedge; returns at the negedge after the sampling posedge.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick2 = 1'b1;
            @(negedge clk);
            frame_tick2 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic set_req(input logic [2:0] m, input logic [2:0] s);
        mode = m;
        select = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (brightness !== 4'd15) begin errors++; $display("FAIL reset_bright got %0d exp 15", brightness); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if ({scene_mode, scene_select} !== 6'd0) begin errors++; $display("FAIL reset_scene got %0d/%0d exp 0/0", scene_mode, scene_select); end
        checks++; if (scroll_x !== 10'd0) begin errors++; $display("FAIL reset_scroll got %0d exp 0", scroll_x); end
    endtask

    task automatic test_idle();
        ticks(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busy); end
        checks++; if (brightness !== 4'd15) begin errors++; $display("FAIL idle_bright got %0d exp 15", brightness); end
        checks++; if (scroll_x !== 10'd20) begin errors++; $display("FAIL idle_scroll got %0d exp 20", scroll_x); end
    endtask

    task automatic test_scene_change();
        set_req(3'd2, 3'd5);
        tick();  // tick 0
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_t0_busy got %0b exp 1", busy); end
        checks++; if (brightness !== 4'd15) begin errors++; $display("FAIL chg_t0_bright got %0d exp 15", brightness); end
        checks++; if (scroll_x !== 10'd22) begin errors++; $display("FAIL chg_t0_scroll got %0d exp 22", scroll_x); end
        tick();  // tick 1
        checks++; if (brightness !== 4'd14) begin errors++; $display("FAIL chg_t1_bright got %0d exp 14", brightness); end
        ticks(13);  // ticks 2..14
        checks++; if (brightness !== 4'd1) begin errors++; $display("FAIL chg_t14_bright got %0d exp 1", brightness); end
        checks++; if (scroll_x !== 10'd50) begin errors++; $display("FAIL chg_t14_scroll got %0d exp 50", scroll_x); end
        checks++; if ({scene_mode, scene_select} !== 6'd0) begin errors++; $display("FAIL chg_t14_scene got %0d/%0d exp 0/0", scene_mode, scene_select); end
        tick();  // tick 15: BLANK
        checks++; if (brightness !== 4'd0) begin errors++; $display("FAIL chg_t15_bright got %0d exp 0", brightness); end
        checks++; if (scene_mode !== 3'd2 || scene_select !== 3'd5) begin errors++; $display("FAIL chg_t15_scene got %0d/%0d exp 2/5", scene_mode, scene_select); end
        checks++; if (scroll_x !== 10'd0) begin errors++; $display("FAIL chg_t15_scroll got %0d exp 0", scroll_x); end
        ticks(2);  // ticks 16,17: scroll frozen, FADE_IN entered at 17
        checks++; if (brightness !== 4'd0 || scroll_x !== 10'd0) begin errors++; $display("FAIL chg_t17 got bright %0d scroll %0d exp 0 0", brightness, scroll_x); end
        tick();  // tick 18
        checks++; if (brightness !== 4'd1 || scroll_x !== 10'd2) begin errors++; $display("FAIL chg_t18 got bright %0d scroll %0d exp 1 2", brightness, scroll_x); end
        ticks(14);  // ticks 19..32
        checks++; if (brightness !== 4'd15) begin errors++; $display("FAIL chg_t32_bright got %0d exp 15", brightness); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_t32_busy got %0b exp 0", busy); end
        checks++; if (scroll_x !== 10'd30) begin errors++; $display("FAIL chg_t32_scroll got %0d exp 30", scroll_x); end
    endtask

    task automatic test_revert();
        // Input change in the same cycle as the tick is not yet seen
        mode = 3'd3;
        select = 3'd1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rev_latency_busy got %0b exp 0", busy); end
        tick();  // tick 0
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rev_t0_busy got %0b exp 1", busy); end
        ticks(4);  // ticks 1..4
        set_req(3'd0, 3'd0);
        ticks(6);  // ticks 5..10
        checks++; if (brightness !== 4'd5 || busy !== 1'b1) begin errors++; $display("FAIL rev_t10 got bright %0d busy %0b exp 5 1", brightness, busy); end
        ticks(5);  // ticks 11..15
        checks++; if (brightness !== 4'd0 || {scene_mode, scene_select} !== 6'd0) begin errors++; $display("FAIL rev_t15 got bright %0d scene %0d/%0d exp 0 0/0", brightness, scene_mode, scene_select); end
        ticks(17);  // ticks 16..32
        checks++; if (brightness !== 4'd15 || busy !== 1'b0) begin errors++; $display("FAIL rev_t32 got bright %0d busy %0b exp 15 0", brightness, busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rev_settled_busy got %0b exp 0", busy); end
    endtask

    task automatic test_change_in_fade_in();
        set_req(3'd1, 3'd0);
        tick();  // tick 0
        ticks(20);  // ticks 1..20, in FADE_IN
        checks++; if (brightness !== 4'd3 || {scene_mode, scene_select} !== {3'd1, 3'd0}) begin errors++; $display("FAIL fin_t20 got bright %0d scene %0d/%0d exp 3 1/0", brightness, scene_mode, scene_select); end
        set_req(3'd1, 3'd6);
        ticks(12);  // ticks 21..32
        checks++; if (brightness !== 4'd15 || busy !== 1'b0) begin errors++; $display("FAIL fin_t32 got bright %0d busy %0b exp 15 0", brightness, busy); end
        checks++; if (scene_select !== 3'd0) begin errors++; $display("FAIL fin_t32_sel got %0d exp 0", scene_select); end
        tick();  // tick 33: new FADE_OUT
        checks++; if (busy !== 1'b1 || brightness !== 4'd15) begin errors++; $display("FAIL fin_t33 got busy %0b bright %0d exp 1 15", busy, brightness); end
        tick();
        checks++; if (brightness !== 4'd14) begin errors++; $display("FAIL fin_t34_bright got %0d exp 14", brightness); end
    endtask

    task automatic test_reset_in_blank();
        ticks(14);  // reaches BLANK
        checks++; if (brightness !== 4'd0 || scene_select !== 3'd6 || busy !== 1'b1) begin errors++; $display("FAIL blk_pre got bright %0d sel %0d busy %0b exp 0 6 1", brightness, scene_select, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (brightness !== 4'd15) begin errors++; $display("FAIL blk_rst_bright got %0d exp 15", brightness); end
        checks++; if ({scene_mode, scene_select} !== 6'd0) begin errors++; $display("FAIL blk_rst_scene got %0d/%0d exp 0/0", scene_mode, scene_select); end
        checks++; if (busy !== 1'b0 || scroll_x !== 10'd0) begin errors++; $display("FAIL blk_rst got busy %0b scroll %0d exp 0 0", busy, scroll_x); end
        set_req(3'd0, 3'd0);
    endtask

    task automatic test_wrap();
        tick2(91);
        checks++; if (scroll_x2 !== 10'd637) begin errors++; $display("FAIL wrap_637 got %0d exp 637", scroll_x2); end
        tick2(1);
        checks++; if (scroll_x2 !== 10'd4) begin errors++; $display("FAIL wrap_4 got %0d exp 4", scroll_x2); end
        tick2(547);
        checks++; if (scroll_x2 !== 10'd633) begin errors++; $display("FAIL wrap_633 got %0d exp 633", scroll_x2); end
        tick2(1);
        checks++; if (scroll_x2 !== 10'd0) begin errors++; $display("FAIL wrap_0 got %0d exp 0", scroll_x2); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle();
        test_scene_change();
        test_revert();
        test_change_in_fade_in();
        test_reset_in_blank();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1, "timeout");
    end
endmodule
